// File: rtl/o_delay_pkg.sv
// Shared types and default constants for the output delay tap controller.
// Both the step FSM and the top import this package.
package o_delay_pkg;

   localparam int TAP_W_DEF       = 6;
   localparam int MAX_TAP_DEF     = 63;
   localparam int SETTLE_CYC_DEF  = 4;
   localparam int STALL_LIMIT_DEF = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      SETTLE,
      CHECK,
      DONE
   } tap_state_e;

endpackage

// File: rtl/o_delay_prims.sv
// Behavioural stand-ins for the vendor O_DELAY and O_BUF cells.
// The real cells are hard macros, so only their port behaviour is reproduced here.
module O_DELAY #(
   parameter int TAP_W = 6
) (
   input  logic             CLK_IN,
   input  logic             DATA_IN,
   input  logic             DLY_LOAD,
   input  logic             DLY_ADJ,
   input  logic             DLY_INCDEC,
   output logic             DATA_OUT,
   output logic [TAP_W-1:0] DLY_TAP_VALUE
);

   logic [TAP_W-1:0] tap_q;

   // The tap chain has no reset pin; it only moves on LOAD or on an ADJ pulse.
   always_ff @(posedge CLK_IN) begin
      if (DLY_LOAD) begin
         tap_q <= '0;
      end else if (DLY_ADJ) begin
         tap_q <= DLY_INCDEC ? tap_q + 1'b1 : tap_q - 1'b1;
      end
   end

   assign DATA_OUT      = DATA_IN;
   assign DLY_TAP_VALUE = tap_q;

endmodule

module O_BUF (
   input  logic I,
   input  logic EN,
   output logic O
);

   // A disabled pad is modelled as driving low rather than floating.
   assign O = EN ? I : 1'b0;

endmodule

// File: rtl/o_delay_step_fsm.sv
// Tap-steering FSM: accepts a target, walks the delay line one ADJ pulse at a time
// and verifies the readback after each step, flagging clamps and stalls.
module o_delay_step_fsm
   import o_delay_pkg::*;
#(
   parameter int TAP_W       = TAP_W_DEF,
   parameter int MAX_TAP     = MAX_TAP_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tap_req_valid_i,
   input  logic [TAP_W-1:0] tap_target_i,
   input  logic             tap_load_i,
   input  logic [TAP_W-1:0] tap_readback_i,
   output logic             tap_req_ready_o,
   output logic             dly_load_o,
   output logic             dly_adj_o,
   output logic             dly_incdec_o,
   output logic [TAP_W-1:0] tap_val_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int CNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

   localparam logic [TAP_W-1:0]   MAX_TAP_L   = TAP_W'(MAX_TAP);
   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_LIMIT - 1);

   tap_state_e         state_q, state_d;
   logic [TAP_W-1:0]   tgt_q, tgt_d;
   logic [TAP_W-1:0]   tap_val_q, tap_val_d;
   logic [TAP_W-1:0]   prev_q, prev_d;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               incdec_q, incdec_d;
   logic               phase_q, phase_d;
   logic               from_load_q, from_load_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic               req_clamped;
   logic [TAP_W-1:0]   req_tgt;
   logic               step_blocked;

   assign req_clamped  = (tap_target_i > MAX_TAP_L);
   assign req_tgt      = req_clamped ? MAX_TAP_L : tap_target_i;
   // Never push the line past either end; a blocked step shows up as a stall.
   assign step_blocked = incdec_q ? (tap_val_q == MAX_TAP_L) : (tap_val_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         tgt_q       <= '0;
         tap_val_q   <= '0;
         prev_q      <= '0;
         settle_q    <= '0;
         stall_q     <= '0;
         incdec_q    <= 1'b0;
         phase_q     <= 1'b0;
         from_load_q <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         tap_val_q   <= tap_val_d;
         prev_q      <= prev_d;
         settle_q    <= settle_d;
         stall_q     <= stall_d;
         incdec_q    <= incdec_d;
         phase_q     <= phase_d;
         from_load_q <= from_load_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   // STEP takes two cycles: a setup cycle with INCDEC already stable, then the ADJ pulse.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      tap_val_d   = tap_val_q;
      prev_d      = prev_q;
      settle_d    = settle_q;
      stall_d     = stall_q;
      incdec_d    = incdec_q;
      phase_d     = phase_q;
      from_load_d = from_load_q;
      err_d       = err_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (tap_load_i) begin
               err_d       = 1'b0;
               from_load_d = 1'b1;
               state_d     = LOAD;
            end else if (tap_req_valid_i) begin
               tgt_d       = req_tgt;
               err_d       = req_clamped;
               stall_d     = '0;
               from_load_d = 1'b0;
               if (req_tgt == tap_val_q) begin
                  state_d = DONE;
               end else begin
                  incdec_d = (req_tgt > tap_val_q);
                  phase_d  = 1'b0;
                  state_d  = STEP;
               end
            end
         end
         LOAD: begin
            settle_d = '0;
            state_d  = SETTLE;
         end
         STEP: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               settle_d = '0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               prev_d    = tap_val_q;
               tap_val_d = tap_readback_i;
               state_d   = CHECK;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         CHECK: begin
            if (from_load_q || (tap_val_q == tgt_q)) begin
               state_d = DONE;
            end else if (tap_val_q == prev_q) begin
               if (stall_q == STALL_LAST) begin
                  stall_d = '0;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  stall_d = stall_q + 1'b1;
                  state_d = STEP;
               end
            end else begin
               stall_d = '0;
               state_d = STEP;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode straight from registered state so an async reset kills them at once.
   assign dly_load_o      = (state_q == LOAD);
   assign dly_adj_o       = (state_q == STEP) && phase_q && !step_blocked;
   assign dly_incdec_o    = incdec_q;
   assign tap_req_ready_o = (state_q == IDLE) && !tap_load_i;
   assign tap_val_o       = tap_val_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: rtl/o_delay_tap_ctrl.sv
// Output delay path top: data_i -> O_DELAY -> O_BUF pad, with the tap-steering FSM
// driving the delay cell's load/adjust controls and reading its tap value back.
module o_delay_tap_ctrl
   import o_delay_pkg::*;
#(
   parameter int TAP_W       = TAP_W_DEF,
   parameter int MAX_TAP     = MAX_TAP_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             data_i,
   output logic             data_o,
   input  logic             tap_req_valid,
   output logic             tap_req_ready,
   input  logic [TAP_W-1:0] tap_target,
   input  logic             tap_load,
   output logic [TAP_W-1:0] tap_val_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   logic             dly_load;
   logic             dly_adj;
   logic             dly_incdec;
   logic             dly_data;
   logic [TAP_W-1:0] dly_tap_value;

   o_delay_step_fsm #(
      .TAP_W       (TAP_W),
      .MAX_TAP     (MAX_TAP),
      .SETTLE_CYC  (SETTLE_CYC),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_step_fsm (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .tap_req_valid_i (tap_req_valid),
      .tap_target_i    (tap_target),
      .tap_load_i      (tap_load),
      .tap_readback_i  (dly_tap_value),
      .tap_req_ready_o (tap_req_ready),
      .dly_load_o      (dly_load),
      .dly_adj_o       (dly_adj),
      .dly_incdec_o    (dly_incdec),
      .tap_val_o       (tap_val_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   // The data path is never gated; glitches while the taps move are tolerated.
   O_DELAY #(
      .TAP_W (TAP_W)
   ) u_odelay (
      .CLK_IN        (clk_i),
      .DATA_IN       (data_i),
      .DLY_LOAD      (dly_load),
      .DLY_ADJ       (dly_adj),
      .DLY_INCDEC    (dly_incdec),
      .DATA_OUT      (dly_data),
      .DLY_TAP_VALUE (dly_tap_value)
   );

   O_BUF u_obuf (
      .I  (dly_data),
      .EN (1'b1),
      .O  (data_o)
   );

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// Self-checking bench for o_delay_tap_ctrl: directed scenarios plus random tap requests,
// checked against a tap/latency model derived from the step and settle rules.
module tb_o_delay_tap_ctrl;

   localparam int TAP_W       = 6;
   localparam int MAX_TAP     = 40;
   localparam int SETTLE_CYC  = 4;
   localparam int STALL_LIMIT = 3;
   localparam int STEP_CYC    = SETTLE_CYC + 3;
   localparam int LOAD_CYC    = SETTLE_CYC + 4;

   logic             clk_i;
   logic             rst_ni;
   logic             data_i;
   logic             data_o;
   logic             tap_req_valid;
   logic             tap_req_ready;
   logic [TAP_W-1:0] tap_target;
   logic             tap_load;
   logic [TAP_W-1:0] tap_val_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   int vectors     = 0;
   int miscompares = 0;
   int curTap      = 0;

   int adjCount    = 0;
   int incCount    = 0;
   int loadCount   = 0;
   int incdecBad   = 0;
   bit adjPrev     = 1'b0;
   bit incPrev     = 1'b0;
   bit incPrev2    = 1'b0;

   o_delay_tap_ctrl #(
      .TAP_W       (TAP_W),
      .MAX_TAP     (MAX_TAP),
      .SETTLE_CYC  (SETTLE_CYC),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .data_i        (data_i),
      .data_o        (data_o),
      .tap_req_valid (tap_req_valid),
      .tap_req_ready (tap_req_ready),
      .tap_target    (tap_target),
      .tap_load      (tap_load),
      .tap_val_o     (tap_val_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Pulse counters and the INCDEC-stable-around-ADJ watcher, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (dut.dly_adj === 1'b1) begin
         adjCount++;
         if (dut.dly_incdec === 1'b1) incCount++;
      end
      if (dut.dly_load === 1'b1) loadCount++;
      if (adjPrev && !((incPrev2 == incPrev) && (incPrev == dut.dly_incdec))) incdecBad++;
      incPrev2 = incPrev;
      incPrev  = dut.dly_incdec;
      adjPrev  = dut.dly_adj;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic clearCounters();
      adjCount  = 0;
      incCount  = 0;
      loadCount = 0;
      incdecBad = 0;
   endtask

   // Offer one target and check the walk against the model: clamp, step count, direction, latency.
   task automatic applyStimulus(input int target, input string tag);
      int  expTgt;
      int  steps;
      int  n;
      bit  expErr;
      expErr = (target > MAX_TAP);
      expTgt = expErr ? MAX_TAP : target;
      steps  = (expTgt > curTap) ? expTgt - curTap : curTap - expTgt;
      checkOutput({tag, ".ready"}, 32'(tap_req_ready), 1);
      clearCounters();
      tap_target    = 6'(target);
      tap_req_valid = 1'b1;
      @(negedge clk_i);
      tap_req_valid = 1'b0;
      n = 1;
      while (done_o !== 1'b1 && n < steps * STEP_CYC + 50) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput({tag, ".latency"}, 32'(n), 32'(steps * STEP_CYC + 2));
      checkOutput({tag, ".tap"}, 32'(tap_val_o), 32'(expTgt));
      checkOutput({tag, ".err"}, 32'(err_o), 32'(expErr));
      checkOutput({tag, ".adj"}, 32'(adjCount), 32'(steps));
      checkOutput({tag, ".inc"}, 32'(incCount), 32'((expTgt > curTap) ? steps : 0));
      checkOutput({tag, ".incdecStable"}, 32'(incdecBad), 0);
      checkOutput({tag, ".load"}, 32'(loadCount), 0);
      @(negedge clk_i);
      checkOutput({tag, ".donePulse"}, 32'(done_o), 0);
      checkOutput({tag, ".idle"}, 32'(busy_o), 0);
      curTap = expTgt;
   endtask

   // tap_load pulse, optionally colliding with a request that must lose.
   task automatic doLoad(input bit alsoValid, input string tag);
      int n;
      clearCounters();
      tap_load      = 1'b1;
      tap_req_valid = alsoValid;
      tap_target    = 6'($urandom_range(0, 63));
      #1;
      checkOutput({tag, ".readyLow"}, 32'(tap_req_ready), 0);
      @(negedge clk_i);
      tap_load      = 1'b0;
      tap_req_valid = 1'b0;
      n = 1;
      while (done_o !== 1'b1 && n < LOAD_CYC + 50) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput({tag, ".latency"}, 32'(n), LOAD_CYC);
      checkOutput({tag, ".loadPulses"}, 32'(loadCount), 1);
      checkOutput({tag, ".adj"}, 32'(adjCount), 0);
      checkOutput({tag, ".tap"}, 32'(tap_val_o), 0);
      checkOutput({tag, ".err"}, 32'(err_o), 0);
      @(negedge clk_i);
      curTap = 0;
   endtask

   initial begin
      int  n;
      int  k;
      bit  sawDone;

      rst_ni        = 1'b0;
      data_i        = 1'b0;
      tap_req_valid = 1'b0;
      tap_target    = '0;
      tap_load      = 1'b0;
      repeat (3) @(negedge clk_i);

      checkOutput("reset.tap", 32'(tap_val_o), 0);
      checkOutput("reset.busy", 32'(busy_o), 0);
      checkOutput("reset.done", 32'(done_o), 0);
      checkOutput("reset.err", 32'(err_o), 0);
      checkOutput("reset.ready", 32'(tap_req_ready), 1);
      checkOutput("reset.adj", 32'(dut.dly_adj), 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      doLoad(1'b0, "init");
      applyStimulus(5, "t1_up5");
      applyStimulus(2, "t2_down2");
      applyStimulus(2, "t3_equal");
      applyStimulus(63, "t4_clamp");

      for (int i = 0; i < 4; i++) begin
         data_i = 1'($urandom);
         #1;
         checkOutput("datapath", 32'(data_o), 32'(data_i));
         @(negedge clk_i);
      end

      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 3) == 0) doLoad(1'($urandom_range(0, 1)), "rand_load");
         else applyStimulus(int'($urandom_range(0, 63)), "rand_req");
      end

      // Frozen readback: the line appears stuck, so the walk must give up with an error.
      applyStimulus(7, "t5_pre");
      force dut.dly_tap_value = 6'd7;
      checkOutput("t5.ready", 32'(tap_req_ready), 1);
      clearCounters();
      tap_target    = 6'd10;
      tap_req_valid = 1'b1;
      @(negedge clk_i);
      tap_req_valid = 1'b0;
      n = 1;
      sawDone = 1'b0;
      while (busy_o === 1'b1 && n < 200) begin
         @(negedge clk_i);
         n++;
         if (done_o === 1'b1) sawDone = 1'b1;
      end
      checkOutput("t5.cycles", 32'(n), 32'(STALL_LIMIT * STEP_CYC + 1));
      checkOutput("t5.adj", 32'(adjCount), STALL_LIMIT);
      checkOutput("t5.err", 32'(err_o), 1);
      checkOutput("t5.noDone", 32'(sawDone), 0);
      checkOutput("t5.ready", 32'(tap_req_ready), 1);
      checkOutput("t5.tap", 32'(tap_val_o), 7);
      release dut.dly_tap_value;
      @(negedge clk_i);
      doLoad(1'b0, "t5_load");

      // Reset in the middle of the fourth ADJ pulse of a walk to 8.
      clearCounters();
      tap_target    = 6'd8;
      tap_req_valid = 1'b1;
      @(negedge clk_i);
      tap_req_valid = 1'b0;
      k = 0;
      n = 0;
      while (k < 4 && n < 200) begin
         @(negedge clk_i);
         n++;
         if (dut.dly_adj === 1'b1) k++;
      end
      checkOutput("t6.pulseReached", 32'(k), 4);
      checkOutput("t6.readback", 32'(dut.dly_tap_value), 3);
      rst_ni = 1'b0;
      #1;
      checkOutput("t6.adjDropped", 32'(dut.dly_adj), 0);
      checkOutput("t6.tap", 32'(tap_val_o), 0);
      checkOutput("t6.busy", 32'(busy_o), 0);
      checkOutput("t6.done", 32'(done_o), 0);
      checkOutput("t6.err", 32'(err_o), 0);
      checkOutput("t6.ready", 32'(tap_req_ready), 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      doLoad(1'b0, "t6_load");
      applyStimulus(4, "t6_after");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
